// File: rtl/key_debounce_pulser_if.sv
// Key conditioning bundle: raw key in, debounced pulses and level out.
// The slave side belongs to the debouncer; the master side drives the raw key.
interface key_debounce_pulser_if;
  logic keyIn;
  logic keyPulse;
  logic releasePulse;
  logic keyLevel;

  modport master (output keyIn, input keyPulse, input releasePulse, input keyLevel);
  modport slave  (input keyIn, output keyPulse, output releasePulse, output keyLevel);
endinterface

// File: rtl/key_debounce_pulser.sv
// Pushbutton conditioner: 2-FF sync, stable-time debounce of press/release, press + auto-repeat pulses.
// States: IDLE released | DEB_PRESS qualifying press | HELD accepted press | DEB_RELEASE qualifying release
module key_debounce_pulser #(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int KEY_ACTIVE_LOW  = 1,
  parameter int REPEAT_EN       = 0,
  parameter int REPEAT_DELAY    = 25000000,
  parameter int REPEAT_PERIOD   = 5000000
) (
  input logic                   clk,
  input logic                   resetN,
  key_debounce_pulser_if.slave  key_if
);

  localparam int MAX_DR = (DEBOUNCE_CYCLES > REPEAT_DELAY) ? DEBOUNCE_CYCLES : REPEAT_DELAY;
  localparam int MAX_P  = (MAX_DR > REPEAT_PERIOD) ? MAX_DR : REPEAT_PERIOD;
  localparam int CW     = $clog2(MAX_P) + 1;

  localparam logic          REL_LVL        = (KEY_ACTIVE_LOW != 0);
  localparam logic [CW-1:0] DB_LAST        = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [CW-1:0] RPT_FIRST_LAST = CW'(REPEAT_DELAY - 1);
  localparam logic [CW-1:0] RPT_NEXT_LAST  = CW'(REPEAT_PERIOD - 1);

  typedef enum logic [1:0] {IDLE, DEB_PRESS, HELD, DEB_RELEASE} state_e;

  state_e        state_q;
  logic          sync1_q, sync2_q;
  logic [CW-1:0] db_cnt_q;
  logic [CW-1:0] rpt_cnt_q;
  logic          first_rpt_q;
  logic          key_pulse_q, rel_pulse_q, key_level_q;
  logic          pressed;

  assign pressed = sync2_q ^ REL_LVL;

  // Synchroniser resets to the released level so reset never looks like a press.
  always_ff @(posedge clk) begin
    if (!resetN) begin
      sync1_q <= REL_LVL;
      sync2_q <= REL_LVL;
    end else begin
      sync1_q <= key_if.keyIn;
      sync2_q <= sync1_q;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetN) begin
      state_q     <= IDLE;
      db_cnt_q    <= '0;
      rpt_cnt_q   <= '0;
      first_rpt_q <= 1'b0;
      key_pulse_q <= 1'b0;
      rel_pulse_q <= 1'b0;
      key_level_q <= 1'b0;
    end else begin
      key_pulse_q <= 1'b0;
      rel_pulse_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (pressed) begin
            state_q  <= DEB_PRESS;
            db_cnt_q <= '0;
          end
        end
        DEB_PRESS: begin
          if (!pressed) begin
            state_q <= IDLE;
          end else if (db_cnt_q == DB_LAST) begin
            state_q     <= HELD;
            key_pulse_q <= 1'b1;
            key_level_q <= 1'b1;
            rpt_cnt_q   <= '0;
            first_rpt_q <= 1'b1;
          end else begin
            db_cnt_q <= db_cnt_q + CW'(1);
          end
        end
        HELD: begin
          if (!pressed) begin
            state_q  <= DEB_RELEASE;
            db_cnt_q <= '0;
          end else if (REPEAT_EN != 0) begin
            if (rpt_cnt_q == (first_rpt_q ? RPT_FIRST_LAST : RPT_NEXT_LAST)) begin
              key_pulse_q <= 1'b1;
              rpt_cnt_q   <= '0;
              first_rpt_q <= 1'b0;
            end else begin
              rpt_cnt_q <= rpt_cnt_q + CW'(1);
            end
          end
        end
        DEB_RELEASE: begin
          // A bounce back to pressed resumes the frozen repeat count rather than restarting it.
          if (pressed) begin
            state_q <= HELD;
          end else if (db_cnt_q == DB_LAST) begin
            state_q     <= IDLE;
            key_level_q <= 1'b0;
            rel_pulse_q <= 1'b1;
          end else begin
            db_cnt_q <= db_cnt_q + CW'(1);
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign key_if.keyPulse     = key_pulse_q;
  assign key_if.releasePulse = rel_pulse_q;
  assign key_if.keyLevel     = key_level_q;

endmodule

// File: tb/tb_key_debounce_pulser.sv
// Bench for key_debounce_pulser: active-low repeating instance plus active-high non-repeating instance.
// Pulse events are encoded as cycle*4+kind (0 kp, 1 rp, 2 kp2, 3 rp2) and matched in order.
module tb_key_debounce_pulser;
  logic clk = 1'b0;
  logic resetN = 1'b0;

  key_debounce_pulser_if kif();
  key_debounce_pulser_if kif2();

  key_debounce_pulser #(
    .DEBOUNCE_CYCLES(4), .KEY_ACTIVE_LOW(1), .REPEAT_EN(1), .REPEAT_DELAY(10), .REPEAT_PERIOD(3)
  ) dut (.clk(clk), .resetN(resetN), .key_if(kif));

  key_debounce_pulser #(
    .DEBOUNCE_CYCLES(4), .KEY_ACTIVE_LOW(0), .REPEAT_EN(0), .REPEAT_DELAY(10), .REPEAT_PERIOD(3)
  ) dut2 (.clk(clk), .resetN(resetN), .key_if(kif2));

  always #5 clk = ~clk;

  int cyc = 0;
  int checks = 0;
  int failures = 0;
  int exp_q[$];
  int obs_q[$];
  int hb;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (kif.keyPulse)      obs_q.push_back(cyc*4 + 0);
    if (kif.releasePulse)  obs_q.push_back(cyc*4 + 1);
    if (kif2.keyPulse)     obs_q.push_back(cyc*4 + 2);
    if (kif2.releasePulse) obs_q.push_back(cyc*4 + 3);
  end

  task automatic wait_to(input int t);
    while (cyc < t) @(negedge clk);
  endtask

  task automatic test_reset();
    int e, o;
    kif.keyIn = 1'b1;
    kif2.keyIn = 1'b0;
    resetN = 1'b0;
    wait_to(3);
    checks++;
    if ({kif.keyPulse, kif.releasePulse, kif.keyLevel, kif2.keyPulse, kif2.releasePulse, kif2.keyLevel} !== 6'b0) begin
      failures++;
      $display("FAIL rst_outputs: got %b%b%b %b%b%b want 000 000", kif.keyPulse, kif.releasePulse,
               kif.keyLevel, kif2.keyPulse, kif2.releasePulse, kif2.keyLevel);
    end
    resetN = 1'b1;
    wait_to(cyc + 8);
    checks++;
    if ({kif.keyLevel, kif2.keyLevel} !== 2'b0) begin
      failures++;
      $display("FAIL idle_level: got %b%b want 00", kif.keyLevel, kif2.keyLevel);
    end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if (obs_q.size() == 0) begin
        failures++; $display("FAIL rst_event: got none want cyc %0d kind %0d", e/4, e%4);
      end else begin
        o = obs_q.pop_front();
        if (o !== e) begin failures++; $display("FAIL rst_event: got cyc %0d kind %0d want cyc %0d kind %0d", o/4, o%4, e/4, e%4); end
      end
    end
    checks++;
    if (obs_q.size() != 0) begin failures++; $display("FAIL rst_extra: got %0d extra events want 0", obs_q.size()); obs_q.delete(); end
  endtask

  task automatic test_glitch();
    int b;
    @(negedge clk);
    b = cyc;
    kif.keyIn = 1'b0;
    wait_to(b + 3);
    kif.keyIn = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      checks++;
      if (kif.keyLevel !== 1'b0) begin failures++; $display("FAIL glitch_level: got %b want 0 at cyc %0d", kif.keyLevel, cyc); end
    end
    checks++;
    if (obs_q.size() != 0) begin failures++; $display("FAIL glitch_pulse: got %0d events want 0", obs_q.size()); obs_q.delete(); end
  endtask

  task automatic test_press();
    int e, o;
    @(negedge clk);
    hb = cyc;
    kif.keyIn = 1'b0;
    exp_q.push_back((hb + 7)*4 + 0);
    wait_to(hb + 6);
    checks++;
    if (kif.keyLevel !== 1'b0) begin failures++; $display("FAIL press_level_early: got %b want 0", kif.keyLevel); end
    wait_to(hb + 7);
    checks++;
    if (kif.keyLevel !== 1'b1) begin failures++; $display("FAIL press_level: got %b want 1", kif.keyLevel); end
    wait_to(hb + 8);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if (obs_q.size() == 0) begin
        failures++; $display("FAIL press_event: got none want cyc %0d kind %0d", e/4, e%4);
      end else begin
        o = obs_q.pop_front();
        if (o !== e) begin failures++; $display("FAIL press_event: got cyc %0d kind %0d want cyc %0d kind %0d", o/4, o%4, e/4, e%4); end
      end
    end
    checks++;
    if (obs_q.size() != 0) begin failures++; $display("FAIL press_extra: got %0d extra events want 0", obs_q.size()); obs_q.delete(); end
  endtask

  task automatic test_repeat();
    int e, o;
    for (int t = 17; t <= 35; t += 3) exp_q.push_back((hb + t)*4 + 0);
    wait_to(hb + 30);
    checks++;
    if (kif.keyLevel !== 1'b1) begin failures++; $display("FAIL repeat_level: got %b want 1", kif.keyLevel); end
    wait_to(hb + 35);
    kif.keyIn = 1'b1;
    wait_to(hb + 36);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if (obs_q.size() == 0) begin
        failures++; $display("FAIL repeat_event: got none want cyc %0d kind %0d", e/4, e%4);
      end else begin
        o = obs_q.pop_front();
        if (o !== e) begin failures++; $display("FAIL repeat_event: got cyc %0d kind %0d want cyc %0d kind %0d", o/4, o%4, e/4, e%4); end
      end
    end
    checks++;
    if (obs_q.size() != 0) begin failures++; $display("FAIL repeat_extra: got %0d extra events want 0", obs_q.size()); obs_q.delete(); end
  endtask

  task automatic test_release_bounce();
    int e, o;
    wait_to(hb + 37);
    kif.keyIn = 1'b0;
    wait_to(hb + 39);
    kif.keyIn = 1'b1;
    exp_q.push_back((hb + 41)*4 + 0);
    exp_q.push_back((hb + 46)*4 + 1);
    wait_to(hb + 45);
    checks++;
    if (kif.keyLevel !== 1'b1) begin failures++; $display("FAIL release_level_hold: got %b want 1", kif.keyLevel); end
    wait_to(hb + 46);
    checks++;
    if (kif.keyLevel !== 1'b0) begin failures++; $display("FAIL release_level: got %b want 0", kif.keyLevel); end
    wait_to(hb + 55);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if (obs_q.size() == 0) begin
        failures++; $display("FAIL release_event: got none want cyc %0d kind %0d", e/4, e%4);
      end else begin
        o = obs_q.pop_front();
        if (o !== e) begin failures++; $display("FAIL release_event: got cyc %0d kind %0d want cyc %0d kind %0d", o/4, o%4, e/4, e%4); end
      end
    end
    checks++;
    if (obs_q.size() != 0) begin failures++; $display("FAIL release_extra: got %0d extra events want 0", obs_q.size()); obs_q.delete(); end
  endtask

  task automatic test_reset_mid_hold();
    int b, e, o;
    @(negedge clk);
    b = cyc;
    kif.keyIn = 1'b0;
    exp_q.push_back((b + 7)*4 + 0);
    wait_to(b + 9);
    resetN = 1'b0;
    wait_to(b + 10);
    checks++;
    if ({kif.keyPulse, kif.releasePulse, kif.keyLevel} !== 3'b0) begin
      failures++; $display("FAIL midrst_outputs: got %b%b%b want 000", kif.keyPulse, kif.releasePulse, kif.keyLevel);
    end
    resetN = 1'b1;
    exp_q.push_back((b + 17)*4 + 0);
    wait_to(b + 18);
    checks++;
    if (kif.keyLevel !== 1'b1) begin failures++; $display("FAIL midrst_relevel: got %b want 1", kif.keyLevel); end
    kif.keyIn = 1'b1;
    exp_q.push_back((b + 25)*4 + 1);
    wait_to(b + 30);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if (obs_q.size() == 0) begin
        failures++; $display("FAIL midrst_event: got none want cyc %0d kind %0d", e/4, e%4);
      end else begin
        o = obs_q.pop_front();
        if (o !== e) begin failures++; $display("FAIL midrst_event: got cyc %0d kind %0d want cyc %0d kind %0d", o/4, o%4, e/4, e%4); end
      end
    end
    checks++;
    if (obs_q.size() != 0) begin failures++; $display("FAIL midrst_extra: got %0d extra events want 0", obs_q.size()); obs_q.delete(); end
  endtask

  task automatic test_alt_polarity();
    int b, e, o;
    @(negedge clk);
    b = cyc;
    kif2.keyIn = 1'b1;
    exp_q.push_back((b + 7)*4 + 2);
    wait_to(b + 30);
    checks++;
    if (kif2.keyLevel !== 1'b1) begin failures++; $display("FAIL alt_level: got %b want 1", kif2.keyLevel); end
    wait_to(b + 50);
    kif2.keyIn = 1'b0;
    exp_q.push_back((b + 57)*4 + 3);
    wait_to(b + 58);
    checks++;
    if (kif2.keyLevel !== 1'b0) begin failures++; $display("FAIL alt_release_level: got %b want 0", kif2.keyLevel); end
    wait_to(b + 70);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if (obs_q.size() == 0) begin
        failures++; $display("FAIL alt_event: got none want cyc %0d kind %0d", e/4, e%4);
      end else begin
        o = obs_q.pop_front();
        if (o !== e) begin failures++; $display("FAIL alt_event: got cyc %0d kind %0d want cyc %0d kind %0d", o/4, o%4, e/4, e%4); end
      end
    end
    checks++;
    if (obs_q.size() != 0) begin failures++; $display("FAIL alt_extra: got %0d extra events want 0", obs_q.size()); obs_q.delete(); end
  endtask

  initial begin
    test_reset();
    test_glitch();
    test_press();
    test_repeat();
    test_release_bounce();
    test_reset_mid_hold();
    test_alt_polarity();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
